// File: rtl/drum_hit_scheduler.sv
// Drum-pad hit scheduler: synchronizes three pad triggers, applies retrigger lockout,
// queues one hit per pad and grants them round-robin to a shared sample-player voice.
module drum_hit_scheduler #(
    parameter int LOCKOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] trig_in,
    input  logic       play_ready,
    output logic       play_valid,
    output logic [1:0] play_sel,
    output logic       hat_hit,
    output logic       cymbal_hit,
    output logic       tom_hit,
    output logic [2:0] pending,
    output logic [7:0] drop_count
);

    localparam int CW = $clog2(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    logic [2:0]    sync1_q, sync2_q, sync3_q;
    logic [CW-1:0] lock_q [3];
    logic [CW-1:0] lock_d [3];
    logic [2:0]    pending_q, pending_d;
    logic [7:0]    drop_q, drop_d;
    logic [8:0]    dropSum;

    state_t        state_q;
    logic          play_valid_q;
    logic [1:0]    play_sel_q;
    logic [1:0]    last_q;
    logic [2:0]    hit_q;

    logic [2:0]    rise;
    logic [2:0]    accept;
    logic [2:0]    clear;
    logic [2:0]    drops;
    logic          handshake;
    logic [1:0]    nextSel;

    // Scan last+1, last+2, last+3 (mod 3); iterating backwards lets the nearest request win.
    function automatic logic [1:0] rrPick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] cand;
        rrPick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(last) + k) % 3);
            if (req[cand]) rrPick = cand;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise      = sync2_q & ~sync3_q;
    assign handshake = (state_q == OFFER) && play_ready;
    assign nextSel   = rrPick(pending_q, last_q);

    always_comb begin
        accept = '0;
        clear  = '0;
        lock_d = lock_q;
        for (int i = 0; i < 3; i++) begin
            accept[i] = rise[i] && (lock_q[i] == '0);
            clear[i]  = handshake && (play_sel_q == 2'(i));
            if (accept[i]) begin
                lock_d[i] = LOCK_LOAD;
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - 1'b1;
            end else begin
                lock_d[i] = '0;
            end
        end
    end

    // A fresh hit on a pad being granted this cycle re-queues instead of counting as a drop.
    always_comb begin
        pending_d = accept | (pending_q & ~clear);
        drops     = accept & pending_q & ~clear;
        dropSum   = {1'b0, drop_q} + 9'($countones(drops));
        drop_d    = dropSum[8] ? 8'hFF : dropSum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) lock_q[i] <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            for (int i = 0; i < 3; i++) lock_q[i] <= lock_d[i];
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            play_valid_q <= 1'b0;
            play_sel_q   <= 2'd0;
            last_q       <= 2'd2;
            hit_q        <= '0;
        end else begin
            hit_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        play_sel_q   <= nextSel;
                        play_valid_q <= 1'b1;
                        state_q      <= OFFER;
                    end
                end
                OFFER: begin
                    if (play_ready) begin
                        play_valid_q <= 1'b0;
                        last_q       <= play_sel_q;
                        hit_q        <= 3'b001 << play_sel_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign play_valid = play_valid_q;
    assign play_sel   = play_sel_q;
    assign hat_hit    = hit_q[0];
    assign cymbal_hit = hit_q[1];
    assign tom_hit    = hit_q[2];
    assign pending    = pending_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_drum_hit_scheduler.sv
// Bench for drum_hit_scheduler: timing table, a hit-order scoreboard and lockout/drop/reset sequences.
module tb_drum_hit_scheduler;

    localparam int LOCK = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] trig_in = 3'b000;
    logic       play_ready = 1'b1;
    logic       play_valid;
    logic [1:0] play_sel;
    logic       hat_hit, cymbal_hit, tom_hit;
    logic [2:0] pending;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;
    int unsigned drumQ[$];

    typedef struct {
        logic       rst;
        logic [2:0] trig;
        logic       ready;
        logic [2:0] pushMask;
        logic [2:0] expPend;
        logic       expValid;
        logic [1:0] expSel;
        logic [2:0] expHit;
        logic [7:0] expDrop;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    drum_hit_scheduler #(.LOCKOUT_CYCLES(LOCK)) dut (
        .clk        (clk),
        .reset      (reset),
        .trig_in    (trig_in),
        .play_ready (play_ready),
        .play_valid (play_valid),
        .play_sel   (play_sel),
        .hat_hit    (hat_hit),
        .cymbal_hit (cymbal_hit),
        .tom_hit    (tom_hit),
        .pending    (pending),
        .drop_count (drop_count)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every hit pulse must match the next drum the stimulus expects to be granted.
    always @(negedge clk) begin
        logic [2:0] h;
        int unsigned expDrum;
        h = {tom_hit, cymbal_hit, hat_hit};
        if (h != 3'b000) begin
            checkValue("hit_onehot", $countones(h), 1);
            if (drumQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_hit actual=%0b expected=none", h);
            end else begin
                expDrum = drumQ.pop_front();
                checkValue("hit_order", {29'd0, h}, 32'd1 << expDrum);
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushDrums(input logic [2:0] mask);
        for (int d = 0; d < 3; d++) if (mask[d]) drumQ.push_back(d);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        trig_in = 3'b000;
        stepCycles(1);
        reset = 1'b0;
        checkValue("rst_valid", play_valid, 0);
        checkValue("rst_sel", play_sel, 0);
        checkValue("rst_hits", {tom_hit, cymbal_hit, hat_hit}, 0);
        checkValue("rst_pending", pending, 0);
        checkValue("rst_drop", drop_count, 0);
    endtask

    task automatic waitValid(input int budget, input string name);
        int c;
        c = 0;
        while (!play_valid && c < budget) begin
            stepCycles(1);
            c++;
        end
        checkValue(name, play_valid, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst) doReset();
        trig_in    = v.trig;
        play_ready = v.ready;
        pushDrums(v.pushMask);
        stepCycles(1);
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkValue($sformatf("row%0d_pending", idx), pending, v.expPend);
        checkValue($sformatf("row%0d_valid", idx), play_valid, v.expValid);
        if (v.expValid) checkValue($sformatf("row%0d_sel", idx), play_sel, v.expSel);
        checkValue($sformatf("row%0d_hits", idx), {tom_hit, cymbal_hit, hat_hit}, v.expHit);
        checkValue($sformatf("row%0d_drop", idx), drop_count, v.expDrop);
    endtask

    initial begin
        logic       seen, broke, wrapped;
        logic [7:0] prevDrop;

        // Single hat: row 0 is the edge that samples the rise.
        vecs.push_back('{1'b1, 3'b001, 1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b001, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b001, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b001, 1'b1, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});
        // All three pads together: hat, cymbal, tom two clocks apart.
        vecs.push_back('{1'b1, 3'b111, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b111, 1'b0, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b111, 1'b1, 2'd0, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b110, 1'b0, 2'd0, 3'b001, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b110, 1'b1, 2'd1, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b100, 1'b0, 2'd0, 3'b010, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b100, 1'b1, 2'd2, 3'b000, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b100, 8'd0});
        vecs.push_back('{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000, 8'd0});

        stepCycles(2);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end
        stepCycles(LOCK);

        $display("[TB] hat bounce");
        doReset();
        play_ready = 1'b1;
        pushDrums(3'b001);
        for (int c = 0; c < 6; c++) begin
            trig_in = (c % 2 == 0) ? 3'b001 : 3'b000;
            stepCycles(1);
        end
        trig_in = 3'b000;
        stepCycles(12);
        checkValue("bounce_drop", drop_count, 0);
        checkValue("bounce_pending", pending, 0);
        checkValue("bounce_valid", play_valid, 0);

        $display("[TB] held tom offer");
        doReset();
        play_ready = 1'b0;
        seen  = 1'b0;
        broke = 1'b0;
        for (int h = 0; h < 4; h++) begin
            for (int c = 0; c < 10; c++) begin
                trig_in = (c < 2) ? 3'b100 : 3'b000;
                stepCycles(1);
                if (play_valid) seen = 1'b1;
                else if (seen) broke = 1'b1;
                if (seen && play_sel != 2'd2) broke = 1'b1;
            end
        end
        checkValue("tom_offer_stable", broke, 0);
        checkValue("tom_valid", play_valid, 1);
        checkValue("tom_sel", play_sel, 2);
        checkValue("tom_drop", drop_count, 3);
        checkValue("tom_pending", pending, 3'b100);
        pushDrums(3'b100);
        play_ready = 1'b1;
        stepCycles(3);
        checkValue("tom_pending_after", pending, 0);
        checkValue("tom_valid_after", play_valid, 0);
        checkValue("tom_drop_after", drop_count, 3);

        $display("[TB] drop saturation");
        doReset();
        play_ready = 1'b0;
        wrapped  = 1'b0;
        prevDrop = 8'd0;
        for (int h = 0; h < 300; h++) begin
            for (int c = 0; c < 10; c++) begin
                trig_in = (c < 2) ? 3'b010 : 3'b000;
                stepCycles(1);
                if (drop_count < prevDrop) wrapped = 1'b1;
                prevDrop = drop_count;
            end
        end
        stepCycles(3);
        checkValue("sat_drop", drop_count, 255);
        checkValue("sat_nowrap", wrapped, 0);
        checkValue("sat_valid", play_valid, 1);
        checkValue("sat_sel", play_sel, 1);
        pushDrums(3'b010);
        play_ready = 1'b1;
        stepCycles(3);
        checkValue("sat_pending_after", pending, 0);
        checkValue("sat_drop_after", drop_count, 255);

        $display("[TB] reset during offer");
        doReset();
        play_ready = 1'b0;
        trig_in    = 3'b001;
        stepCycles(2);
        trig_in = 3'b000;
        waitValid(8, "mid_offer_valid");
        doReset();
        stepCycles(4);
        checkValue("post_rst_pending", pending, 0);
        checkValue("post_rst_valid", play_valid, 0);
        play_ready = 1'b1;
        trig_in    = 3'b101;
        pushDrums(3'b101);
        stepCycles(2);
        trig_in = 3'b000;
        stepCycles(10);
        checkValue("post_rst_served", pending, 0);
        checkValue("post_rst_drop", drop_count, 0);

        stepCycles(2);
        checkValue("scoreboard_empty", drumQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
